chain_access_ctrl: RTL and testbench

CHAIN_ACCESS_CTRL -- requirements
Module: chain_access_ctrl

---
 rtl/chain_access_ctrl.sv | 87 ++++++++
 tb/tb_chain_access_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/chain_access_ctrl.sv
// chain_access_ctrl: sequences distance/ordering chain dumps node by node with a rotating base index.
module chain_access_ctrl #(
  parameter int NODE_NUM  = 32,
  parameter int BASE_NUM  = 4,
  parameter int ORD_BEATS = 8,
  localparam int BIW = (BASE_NUM > 1) ? $clog2(BASE_NUM) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  input  logic           req_op,
  output logic           req_ready,
  input  logic           running,
  input  logic           abort,
  input  logic           out_ready,
  input  logic           ord_ready,
  output logic           distance_shift,
  output logic           ordering_read,
  output logic           chain_sel,
  output logic [BIW-1:0] base_id,
  output logic           busy,
  output logic           done
);
  localparam int NW  = $clog2(NODE_NUM);
  localparam int BTW = (ORD_BEATS > 2) ? $clog2(ORD_BEATS) : 1;
  localparam logic [NW-1:0]  N_ONE = 1;
  localparam logic [BTW-1:0] B_ONE = 1;
  localparam logic [BIW-1:0] I_ONE = 1;

  typedef enum logic [1:0] {IDLE, DIS, ORD, FIN} state_t;

  state_t         state_q, state_d;
  logic [NW-1:0]  node_q, node_d;
  logic [BTW-1:0] beat_q, beat_d;
  logic [BIW-1:0] base_q, base_d;
  logic           fire, beat_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      node_q  <= '0;
      beat_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      node_q  <= node_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
    end
  end

  // pulses depend only on registered state and the gating inputs, never on req_valid
  assign distance_shift = (state_q == DIS) && out_ready && !abort;
  assign ordering_read  = (state_q == ORD) && out_ready && ord_ready && !abort;
  assign fire           = distance_shift || ordering_read;
  assign beat_end       = beat_q == ((state_q == ORD) ? BTW'(ORD_BEATS - 1) : B_ONE);
  assign chain_sel      = (state_q == DIS) ? ~beat_q[0] : (state_q == ORD) ? beat_q[BTW-1] : 1'b0;
  assign req_ready      = (state_q == IDLE) && !running && !abort;
  assign busy           = state_q != IDLE;
  assign done           = state_q == FIN;
  assign base_id        = base_q;

  always_comb begin
    state_d = state_q;
    node_d  = node_q;
    beat_d  = beat_q;
    base_d  = base_q;
    case (state_q)
      IDLE: if (req_valid && req_ready) begin
        state_d = req_op ? ORD : DIS;
        node_d  = '0;
        beat_d  = '0;
      end
      DIS, ORD: if (abort) begin
        state_d = FIN;
      end else if (fire) begin
        beat_d = beat_end ? '0 : beat_q + B_ONE;
        if (beat_end) begin
          node_d  = node_q + N_ONE;
          base_d  = (base_q == BIW'(BASE_NUM - 1)) ? '0 : base_q + I_ONE;
          state_d = (node_q == NW'(NODE_NUM - 1)) ? FIN : state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_chain_access_ctrl.sv
// tb_chain_access_ctrl: scoreboard bench; stimulus queues expected pulses/done, a negedge monitor checks them.
module tb_chain_access_ctrl;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_op = 0, running = 0, abort = 0, out_ready = 0, ord_ready = 0;
  logic req_ready, distance_shift, ordering_read, chain_sel, busy, done;
  logic [1:0] base_id;
  int total = 0, bad = 0;

  typedef struct {
    logic [1:0] kind;
    logic       cs;
    logic [1:0] bid;
  } exp_t;
  exp_t sb[$];

  chain_access_ctrl #(.NODE_NUM(4), .BASE_NUM(4), .ORD_BEATS(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
    .running(running), .abort(abort), .out_ready(out_ready), .ord_ready(ord_ready),
    .distance_shift(distance_shift), .ordering_read(ordering_read), .chain_sel(chain_sel),
    .base_id(base_id), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // kind 0 = distance pulse, 1 = ordering pulse, 2 = done
  task automatic exp_dump(input bit op, input int b0, input int n, input bit wd, input int db);
    exp_t e;
    int node;
    for (int i = 0; i < n; i++) begin
      node   = op ? i / 8 : i / 2;
      e.kind = op ? 2'd1 : 2'd0;
      e.cs   = op ? ((i % 8) >= 4) : ((i % 2) == 0);
      e.bid  = 2'((b0 + node) % 4);
      sb.push_back(e);
    end
    if (wd) begin
      e.kind = 2'd2;
      e.cs   = 1'b0;
      e.bid  = 2'(db);
      sb.push_back(e);
    end
  endtask

  task automatic run_done(input bit tog);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (tog) ord_ready = ~ord_ready;
      if (done) return;
    end
    total++;
    bad++;
    $display("FAIL done_timeout: got no done, expected done within 300 cycles");
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [1:0] ak;
    if (!reset && (distance_shift || ordering_read || done)) begin
      total++;
      ak = done ? 2'd2 : ordering_read ? 2'd1 : 2'd0;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got kind=%0d cs=%0b bid=%0d, expected none", ak, chain_sel, base_id);
      end else begin
        e = sb.pop_front();
        if (ak != e.kind || base_id != e.bid || (e.kind != 2 && chain_sel != e.cs) ||
            (distance_shift && ordering_read) || (distance_shift && !out_ready) ||
            (ordering_read && !(out_ready && ord_ready))) begin
          bad++;
          $display("FAIL event: got kind=%0d cs=%0b bid=%0d or=%0b rdy=%0b, expected kind=%0d cs=%0b bid=%0d",
                   ak, chain_sel, base_id, out_ready, ord_ready, e.kind, e.cs, e.bid);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_base", base_id, 0);
    chk("rst_cs", chain_sel, 0);
    chk("rst_pulses", {distance_shift, ordering_read}, 0);

    // full distance dump, out_ready held high
    exp_dump(0, 0, 8, 1, 0);
    req_op = 0; req_valid = 1; out_ready = 1;
    @(posedge clk); #1 req_valid = 0;
    chk("dis_busy", busy, 1);
    run_done(0);
    @(posedge clk); #1;
    chk("dis_end_base", base_id, 0);
    chk("dis_end_ready", req_ready, 1);

    // distance dump with a 5-cycle out_ready stall mid-node
    exp_dump(0, 0, 8, 1, 0);
    req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    repeat (3) @(posedge clk);
    #1 out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_no_pulse", distance_shift, 0);
    end
    @(posedge clk); #1 out_ready = 1;
    run_done(0);
    @(posedge clk); #1;

    // ordering dump with ord_ready toggling 1,0
    exp_dump(1, 0, 32, 1, 0);
    req_op = 1; req_valid = 1; ord_ready = 1;
    @(posedge clk); #1 req_valid = 0;
    run_done(1);
    ord_ready = 1;
    @(posedge clk); #1;

    // abort after the 3rd distance pulse
    exp_dump(0, 0, 3, 1, 1);
    req_op = 0; req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    repeat (3) @(posedge clk);
    #1 abort = 1;
    #1;
    chk("abort_no_pulse", distance_shift, 0);
    chk("abort_req_ready", req_ready, 0);
    @(posedge clk); #1 abort = 0;
    chk("abort_done", done, 1);
    chk("abort_base", base_id, 1);
    @(posedge clk); #1;
    chk("abort_ready_after", req_ready, 1);

    // running blocks acceptance; running mid-dump does not stop it
    exp_dump(0, 1, 8, 1, 1);
    running = 1; req_valid = 1;
    #1;
    chk("run_block_ready", req_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("run_block_busy", busy, 0);
    running = 0;
    #1;
    chk("run_drop_ready", req_ready, 1);
    @(posedge clk); #1 req_valid = 0;
    chk("run_accept_busy", busy, 1);
    running = 1;
    run_done(0);
    running = 0;
    @(posedge clk); #1;

    // async reset mid-ordering dump
    exp_dump(1, 1, 5, 0, 0);
    req_op = 1; req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    repeat (5) @(posedge clk);
    #3 reset = 1;
    #1;
    chk("arst_outputs", {distance_shift, ordering_read, chain_sel, busy, done}, 0);
    chk("arst_base", base_id, 0);
    @(posedge clk); #2 reset = 0;
    @(negedge clk);
    chk("arst_ready", req_ready, 1);
    exp_dump(1, 0, 32, 1, 0);
    req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    run_done(0);
    @(posedge clk); #1;
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
